// File: rtl/fetch_hazard_ctrl_pkg.sv
// Purpose: shared types and constants for the fetch hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } state_t;

    // ori $0,$0,0 -- the bubble instruction fed to ID when nop_sel_out=1
    localparam logic [31:0] NOP_INSTR = 32'h34000000;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

    // True when an ID source operand is read and names the EX load target.
    function automatic logic reg_match(input logic       used,
                                       input logic [4:0] src,
                                       input logic [4:0] dst);
        return used && (src == dst);
    endfunction

endpackage

// File: rtl/fetch_hazard_ctrl_if.sv
// Purpose: bundle of pipeline-status inputs and fetch-control outputs.
// Latency: n/a (wires only).
// Backpressure: n/a; imem_ready_in is the only stall source from memory.
// Modports: master = pipeline/datapath side, slave = controller side.
interface fetch_hazard_ctrl_if;
    logic [4:0] rs_in;
    logic [4:0] rt_in;
    logic       uses_rs_in;
    logic       uses_rt_in;
    logic       ex_load_in;
    logic [4:0] ex_rt_in;
    logic       redirect_in;
    logic       imem_ready_in;
    logic       pc_en_out;
    logic       pc_redirect_sel_out;
    logic       ifid_en_out;
    logic       nop_sel_out;
    logic       flush_out;
    logic [1:0] state_out;

    modport master (
        output rs_in, rt_in, uses_rs_in, uses_rt_in, ex_load_in, ex_rt_in,
               redirect_in, imem_ready_in,
        input  pc_en_out, pc_redirect_sel_out, ifid_en_out, nop_sel_out,
               flush_out, state_out
    );

    modport slave (
        input  rs_in, rt_in, uses_rs_in, uses_rt_in, ex_load_in, ex_rt_in,
               redirect_in, imem_ready_in,
        output pc_en_out, pc_redirect_sel_out, ifid_en_out, nop_sel_out,
               flush_out, state_out
    );
endinterface

// File: rtl/fetch_hazard_ctrl_sat_counter.sv
// Purpose: W-bit event counter that sticks at all-ones.
// Latency: count reflects inc one cycle later.
// Backpressure: none; inc is sampled every cycle.
// Ports: clk, reset (async active-low clear), inc, count.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Purpose: fetch-stage sequencer -- PC enable/redirect, IF/ID enable, NOP mux, flush.
// Latency: Mealy outputs, same cycle as the inputs; state advances on clk.
// Backpressure: stalls PC and IF/ID on imem_ready_in=0 and on load-use hazards.
// Ports: clk, reset (async active-low), ctrl (fetch_hazard_ctrl_if.slave);
//        with FETCH_HAZARD_PERF_EN defined also stall_cnt_out, flush_cnt_out.
module fetch_hazard_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES      = 1,
    parameter int LOAD_STALL_CYCLES = 1
`ifdef FETCH_HAZARD_PERF_EN
    ,
    parameter int CNT_W             = 16
`endif
) (
    input  logic                clk,
    input  logic                reset,
    fetch_hazard_ctrl_if.slave  ctrl
`ifdef FETCH_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]    stall_cnt_out,
    output logic [CNT_W-1:0]    flush_cnt_out
`endif
);
    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);
    // The RUN cycle that detects the hazard is itself the first stall cycle.
    localparam logic [2:0] STALL_LD = 3'(LOAD_STALL_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       hazard;
    logic       pc_en, pc_sel, ifid_en, nop_sel, flush;

    always_comb begin
        hazard = ctrl.ex_load_in && (ctrl.ex_rt_in != REG_ZERO) &&
                 (reg_match(ctrl.uses_rs_in, ctrl.rs_in, ctrl.ex_rt_in) ||
                  reg_match(ctrl.uses_rt_in, ctrl.rt_in, ctrl.ex_rt_in));

        pc_en     = 1'b0;
        pc_sel    = 1'b0;
        ifid_en   = 1'b0;
        nop_sel   = 1'b1;
        flush     = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;

        if (!reset) begin
            // Outputs are forced while reset is low so the bubble is visible
            // even before the first clock edge.
            flush = 1'b1;
        end else if (ctrl.redirect_in) begin
            // Target is on the datapath now; load it regardless of imem.
            pc_en     = 1'b1;
            pc_sel    = 1'b1;
            ifid_en   = 1'b1;
            flush     = 1'b1;
            state_nxt = ST_FLUSH;
            cnt_nxt   = FLUSH_LD;
        end else if (state == ST_LOAD_STALL) begin
            // PC is frozen, so imem_ready_in is irrelevant here.
            if (cnt == 3'd1) state_nxt = ST_RUN;
            else             cnt_nxt   = cnt - 3'd1;
        end else if (state == ST_FLUSH) begin
            pc_en   = ctrl.imem_ready_in;
            ifid_en = 1'b1;
            flush   = 1'b1;
            if (ctrl.imem_ready_in) begin
                if (cnt == 3'd1) state_nxt = ST_RUN;
                else             cnt_nxt   = cnt - 3'd1;
            end
        end else if (!ctrl.imem_ready_in) begin
            // RUN or MEM_WAIT without data: wait, hazard re-checked later.
            state_nxt = ST_MEM_WAIT;
        end else if (hazard) begin
            // RUN, or the MEM_WAIT cycle in which data arrives.
            if (LOAD_STALL_CYCLES == 1) begin
                state_nxt = ST_RUN;
            end else begin
                state_nxt = ST_LOAD_STALL;
                cnt_nxt   = STALL_LD;
            end
        end else begin
            pc_en     = 1'b1;
            ifid_en   = 1'b1;
            nop_sel   = 1'b0;
            state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_FLUSH;
            cnt   <= FLUSH_LD;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign ctrl.pc_en_out           = pc_en;
    assign ctrl.pc_redirect_sel_out = pc_sel;
    assign ctrl.ifid_en_out         = ifid_en;
    assign ctrl.nop_sel_out         = nop_sel;
    assign ctrl.flush_out           = flush;
    assign ctrl.state_out           = state;

`ifdef FETCH_HAZARD_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~pc_en),
        .count (stall_cnt_out)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ctrl.redirect_in),
        .count (flush_cnt_out)
    );
`endif
endmodule

// File: doc/fetch_hazard_ctrl.md
Name: fetch_hazard_ctrl

Overview:
- Sequences the fetch stage: PC register enable, PC redirect select, IF/ID register enable, and the instruction/no-op mux select.
- Detects load-use hazards, absorbs taken branches and jumps by flushing wrong-path fetches, and stalls on instruction-memory wait.
- Sits beside the fetch module and drives its PC enable, its redirect mux, and the instruction/no-op mux that feeds ID.
- The instruction ROM is synchronous (1-cycle read), so one fetch is always in flight.

Parameters:
- FLUSH_CYCLES, 1: bubble cycles injected after a redirect (range 1..7).
- LOAD_STALL_CYCLES, 1: total stall cycles per load-use hazard (range 1..7).
- CNT_W, 16: width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rs_in  in  5  rs field of the instruction in ID.
- rt_in  in  5  rt field of the instruction in ID.
- uses_rs_in  in  1  the ID instruction reads rs.
- uses_rt_in  in  1  the ID instruction reads rt.
- ex_load_in  in  1  the instruction in EX is a load.
- ex_rt_in  in  5  destination register of the EX load.
- redirect_in  in  1  taken branch or jump resolved this cycle; the target is valid on the datapath this cycle.
- imem_ready_in  in  1  instruction memory data is valid.
- pc_en_out  out  1  PC register load enable.
- pc_redirect_sel_out  out  1  1 selects the redirect target, 0 selects PC+4.
- ifid_en_out  out  1  IF/ID register enable.
- nop_sel_out  out  1  1 forces NOP (32'h34000000) into the downstream stage.
- flush_out  out  1  discard the current IF/ID contents.
- state_out  out  2  current FSM state.

Behaviour:
- States: RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3.
- A 3-bit down-counter cnt holds the remaining cycles in LOAD_STALL or FLUSH.
- Reset asserted (reset=0):
  - state=FLUSH, cnt=FLUSH_CYCLES.
  - Outputs: pc_en=0, pc_redirect_sel=0, ifid_en=0, nop_sel=1, flush=1.
  - This guarantees the first synchronous ROM read after release is bubbled.
  - Reset mid-operation aborts any state immediately; no pending event survives.
- Outputs are Mealy: state plus current inputs, with no extra latency.
- Event priority, highest first: redirect > imem wait > load-use > normal.
- hazard = ex_load_in & (ex_rt_in!=0) & ((uses_rs_in & rs_in==ex_rt_in) | (uses_rt_in & rt_in==ex_rt_in)). Register 0 never causes a hazard.
- Redirect (any state other than reset):
  - Same cycle: pc_en=1, pc_redirect_sel=1, flush=1, nop_sel=1, ifid_en=1.
  - Next state FLUSH with cnt=FLUSH_CYCLES.
  - Aborts LOAD_STALL, FLUSH (counter reloads) and MEM_WAIT; the PC load does not depend on imem_ready_in.
- RUN:
  - imem_ready_in=0: pc_en=0, ifid_en=0, nop_sel=1; next state MEM_WAIT.
  - Else if hazard: pc_en=0, ifid_en=0, nop_sel=1, flush=0.
    - LOAD_STALL_CYCLES=1: next state RUN.
    - Otherwise: next state LOAD_STALL with cnt=LOAD_STALL_CYCLES-1.
  - Else: pc_en=1, ifid_en=1, all other outputs 0.
- LOAD_STALL:
  - Outputs as for a hazard cycle; cnt decrements each cycle.
  - At cnt==1 the next state is RUN.
  - imem_ready_in is ignored here because the PC is frozen.
- FLUSH:
  - Outputs: pc_en=imem_ready_in, ifid_en=1, nop_sel=1, flush=1.
  - cnt decrements only while imem_ready_in=1.
  - At cnt==1 with imem_ready_in=1, the next state is RUN.
- MEM_WAIT:
  - Outputs: pc_en=0, ifid_en=0, nop_sel=1.
  - When imem_ready_in=1, the next state is RUN. That cycle behaves as RUN, including hazard evaluation.
- Simultaneous hazard and imem wait: MEM_WAIT wins. The hazard is re-evaluated in RUN.
- Outputs pc_en_out and ifid_en_out are never both 1 while nop_sel_out=1, except during redirect and FLUSH cycles.

Optional Feature:
- Macro: FETCH_HAZARD_PERF_EN.
- Defined:
  - Adds outputs stall_cnt_out[CNT_W-1:0] (counts cycles with pc_en_out=0 outside reset) and flush_cnt_out[CNT_W-1:0] (counts redirect events).
  - Both counters saturate at all-ones and clear on reset.
- Undefined: the ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_ctrl_pkg:
  - State typedef with the encodings above.
  - NOP_INSTR=32'h34000000.
  - REG_ZERO=5'd0.
- One natural sub-module: sat_counter (parameter W; ports clk, reset, inc, count), instantiated twice under the macro.

Test Plan:
- Reset held low for 3 cycles, then released with imem_ready_in=1 -> state_out=2 with nop_sel=1 for 1 cycle, then state_out=0 and pc_en=1.
- ex_load_in=1, ex_rt_in=8, rs_in=8, uses_rs_in=1 -> exactly 1 cycle with pc_en=0, ifid_en=0, nop_sel=1. Repeat with ex_rt_in=0 -> no stall.
- redirect_in pulse in RUN -> pc_redirect_sel=1 and flush=1 that cycle, 1 FLUSH cycle, then RUN. With FLUSH_CYCLES=3 -> 3 FLUSH cycles.
- Hazard and redirect in the same cycle -> redirect behaviour only, pc_en=1. Redirect during LOAD_STALL (LOAD_STALL_CYCLES=3) -> the stall aborts and FLUSH is entered.
- imem_ready_in low for 4 cycles while in RUN -> 4 cycles in MEM_WAIT with pc_en=0; imem_ready_in low during FLUSH -> cnt holds.
- With FETCH_HAZARD_PERF_EN and CNT_W=2 -> 5 stall cycles leave stall_cnt_out=3 (saturated); 2 redirects give flush_cnt_out=2.
